// File: rtl/dcache_inval_sequencer.sv
// Invalidation walker for the data-cache tag/valid SRAM: clears every set after reset and on
// flush, and otherwise passes the cache controller's accesses straight through to the SRAM.
module dcache_inval_sequencer #(
    parameter int unsigned NumSets = 256,
    parameter int unsigned NumWays = 8,
    localparam int unsigned IdxW   = $clog2(NumSets)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_req_i,
    output logic               flush_ack_o,
    output logic               init_done_o,
    output logic               busy_o,
    input  logic               req_i,
    input  logic               req_we_i,
    input  logic [IdxW-1:0]    req_index_i,
    input  logic [NumWays-1:0] req_way_mask_i,
    input  logic               req_valid_i,
    output logic               gnt_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [IdxW-1:0]    sram_index_o,
    output logic [NumWays-1:0] sram_way_mask_o,
    output logic               sram_valid_o
);

    typedef enum logic [1:0] {StInit, StIdle, StFlush, StDone} state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

    state_e          state_q;
    logic [IdxW-1:0] cnt_q;
    logic            init_done_q;
    logic            flush_ack_q;
    logic            walking;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            flush_ack_q <= 1'b0;
        end else begin
            flush_ack_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + IdxW'(1);
                    if (cnt_q == LastIdx) begin
                        state_q     <= StIdle;
                        init_done_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (flush_req_i) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    cnt_q <= cnt_q + IdxW'(1);
                    if (cnt_q == LastIdx) begin
                        state_q     <= StDone;
                        flush_ack_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

    assign walking     = (state_q == StInit) || (state_q == StFlush);
    assign busy_o      = walking;
    assign init_done_o = init_done_q;
    assign flush_ack_o = flush_ack_q;

    // A pending flush wins over the controller in the IDLE cycle it is seen.
    assign gnt_o = (state_q == StIdle) && !flush_req_i && req_i;

    assign sram_req_o      = walking || gnt_o;
    assign sram_we_o       = walking || (gnt_o && req_we_i);
    assign sram_index_o    = walking ? cnt_q : req_index_i;
    assign sram_way_mask_o = walking ? {NumWays{1'b1}} : req_way_mask_i;
    assign sram_valid_o    = walking ? 1'b0 : req_valid_i;

endmodule

// File: tb/tb_dcache_inval_sequencer.sv
// Directed bench for dcache_inval_sequencer: init walk, passthrough, flush, reset abort, re-flush.
module tb_dcache_inval_sequencer;

    localparam int unsigned NumSets = 256;
    localparam int unsigned NumWays = 8;
    localparam int unsigned IdxW    = 8;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_req_i;
    logic               flush_ack_o;
    logic               init_done_o;
    logic               busy_o;
    logic               req_i;
    logic               req_we_i;
    logic [IdxW-1:0]    req_index_i;
    logic [NumWays-1:0] req_way_mask_i;
    logic               req_valid_i;
    logic               gnt_o;
    logic               sram_req_o;
    logic               sram_we_o;
    logic [IdxW-1:0]    sram_index_o;
    logic [NumWays-1:0] sram_way_mask_o;
    logic               sram_valid_o;

    int n_chk = 0;
    int n_err = 0;

    dcache_inval_sequencer #(
        .NumSets(NumSets),
        .NumWays(NumWays)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_req_i    (flush_req_i),
        .flush_ack_o    (flush_ack_o),
        .init_done_o    (init_done_o),
        .busy_o         (busy_o),
        .req_i          (req_i),
        .req_we_i       (req_we_i),
        .req_index_i    (req_index_i),
        .req_way_mask_i (req_way_mask_i),
        .req_valid_i    (req_valid_i),
        .gnt_o          (gnt_o),
        .sram_req_o     (sram_req_o),
        .sram_we_o      (sram_we_o),
        .sram_index_o   (sram_index_o),
        .sram_way_mask_o(sram_way_mask_o),
        .sram_valid_o   (sram_valid_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish errors=%0d checks=%0d",
                 n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk n cycles from the current negedge, expecting indices 0..n-1; ends on a negedge.
    task automatic walk(input string tag, input int n, input logic exp_done);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_index_o !== IdxW'(i) ||
                sram_way_mask_o !== 8'hFF || sram_valid_o !== 1'b0 || gnt_o !== 1'b0 ||
                busy_o !== 1'b1 || flush_ack_o !== 1'b0 || init_done_o !== exp_done) begin
                bad++;
            end
            @(negedge clk_i);
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_req_i    = 1'b0;
        req_i          = 1'b1;
        req_we_i       = 1'b1;
        req_index_i    = 8'd5;
        req_way_mask_i = 8'h33;
        req_valid_i    = 1'b1;

        // Reset state
        #1;
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        chk("rst_ack", 32'(flush_ack_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_index", 32'(sram_index_o), 32'd0);

        // 1: post-reset walk, controller held off throughout
        @(negedge clk_i);
        rst_ni = 1'b1;
        walk("init_walk", 256, 1'b0);
        #1;
        chk("init_done_rise", 32'(init_done_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_pending_gnt", 32'(gnt_o), 32'd1);

        // 2: passthrough
        @(negedge clk_i);
        req_i = 1'b1; req_we_i = 1'b1; req_index_i = 8'd17;
        req_way_mask_i = 8'h04; req_valid_i = 1'b1;
        #1;
        chk("pt_gnt", 32'(gnt_o), 32'd1);
        chk("pt_req", 32'(sram_req_o), 32'd1);
        chk("pt_we", 32'(sram_we_o), 32'd1);
        chk("pt_index", 32'(sram_index_o), 32'd17);
        chk("pt_mask", 32'(sram_way_mask_o), 32'h04);
        chk("pt_valid", 32'(sram_valid_o), 32'd1);
        @(negedge clk_i);
        req_i = 1'b0; req_we_i = 1'b1; req_index_i = 8'd200;
        req_way_mask_i = 8'hA5; req_valid_i = 1'b0;
        #1;
        chk("noreq_gnt", 32'(gnt_o), 32'd0);
        chk("noreq_sram_req", 32'(sram_req_o), 32'd0);
        chk("noreq_we", 32'(sram_we_o), 32'd0);
        chk("noreq_index", 32'(sram_index_o), 32'd200);
        chk("noreq_mask", 32'(sram_way_mask_o), 32'hA5);

        // 3: flush beats a simultaneous controller request
        @(negedge clk_i);
        flush_req_i = 1'b1; req_i = 1'b1; req_index_i = 8'd17;
        req_way_mask_i = 8'h04; req_valid_i = 1'b1;
        #1;
        chk("fl_gnt_blocked", 32'(gnt_o), 32'd0);
        chk("fl_sram_idle", 32'(sram_req_o), 32'd0);
        @(negedge clk_i);
        walk("flush_walk", 256, 1'b1);
        #1;
        chk("fl_ack", 32'(flush_ack_o), 32'd1);
        chk("fl_done_gnt", 32'(gnt_o), 32'd0);
        chk("fl_done_sram", 32'(sram_req_o), 32'd0);
        chk("fl_done_busy", 32'(busy_o), 32'd0);
        flush_req_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("fl_ack_pulse", 32'(flush_ack_o), 32'd0);
        chk("fl_post_gnt", 32'(gnt_o), 32'd1);
        chk("fl_post_index", 32'(sram_index_o), 32'd17);

        // 4: flush held from reset
        @(negedge clk_i);
        rst_ni = 1'b0; flush_req_i = 1'b1;
        #1;
        chk("r4_init_done", 32'(init_done_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        walk("r4_init_walk", 256, 1'b0);
        #1;
        chk("r4_idle_gnt", 32'(gnt_o), 32'd0);
        chk("r4_idle_busy", 32'(busy_o), 32'd0);
        chk("r4_idle_done", 32'(init_done_o), 32'd1);
        @(negedge clk_i);
        walk("r4_flush_walk", 256, 1'b1);
        #1;
        chk("r4_ack", 32'(flush_ack_o), 32'd1);
        flush_req_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("r4_single_ack", 32'(flush_ack_o), 32'd0);
        chk("r4_idle_after", 32'(busy_o), 32'd0);

        // 5: reset during flush at index 100
        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        walk("r5_part_walk", 100, 1'b1);
        #1;
        chk("r5_at_100", 32'(sram_index_o), 32'd100);
        rst_ni = 1'b0; flush_req_i = 1'b0;
        #1;
        chk("r5_rst_index", 32'(sram_index_o), 32'd0);
        chk("r5_rst_done", 32'(init_done_o), 32'd0);
        chk("r5_rst_ack", 32'(flush_ack_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        walk("r5_rewalk", 256, 1'b0);
        #1;
        chk("r5_done", 32'(init_done_o), 32'd1);
        chk("r5_no_ack", 32'(flush_ack_o), 32'd0);

        // 6: flush request held past ack triggers a second flush
        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        walk("r6_walk1", 256, 1'b1);
        #1;
        chk("r6_ack1", 32'(flush_ack_o), 32'd1);
        @(negedge clk_i);
        #1;
        chk("r6_idle_ack", 32'(flush_ack_o), 32'd0);
        chk("r6_idle_busy", 32'(busy_o), 32'd0);
        chk("r6_idle_gnt", 32'(gnt_o), 32'd0);
        @(negedge clk_i);
        flush_req_i = 1'b0;
        walk("r6_walk2", 256, 1'b1);
        #1;
        chk("r6_ack2", 32'(flush_ack_o), 32'd1);
        @(negedge clk_i);
        #1;
        chk("r6_end_ack", 32'(flush_ack_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("r6_stay_idle", 32'(busy_o), 32'd0);
        chk("r6_end_gnt", 32'(gnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
